// File: rtl/uart_cpld_responder.sv
// uart_cpld_responder
//   Device-side model of the CPLD UART reached through the uart_rdn/uart_wrn
//   strobes and the shared low data byte. Parallel writes become 8N1 frames on
//   txd; 8N1 frames on rxd are assembled into a receive holding byte.
//
//   Parameter CLKS_PER_BIT : clk cycles per serial bit (even, >= 4).
//
//   Ports
//     clk            system clock, rising edge
//     rst            asynchronous reset, active-high
//     uart_data      shared byte bus; driven with RBR while uart_rdn=0 and
//                    uart_wrn=1, otherwise Z
//     uart_rdn       read strobe, active-low, synchronous
//     uart_wrn       write strobe, active-low, synchronous
//     uart_dataready RBR holds an unread byte
//     uart_tbre      transmit holding register empty
//     uart_tsre      transmit shift register empty (line idle)
//     rxd            serial input, asynchronous, idle high
//     txd            serial output, idle high
module uart_cpld_responder #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    inout  wire  [7:0] uart_data,
    input  logic       uart_rdn,
    input  logic       uart_wrn,
    output logic       uart_dataready,
    output logic       uart_tbre,
    output logic       uart_tsre,
    input  logic       rxd,
    output logic       txd
);

    localparam int unsigned  CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- host strobes ----------------
    logic       rdn_d, wrn_d;
    logic       wr_bad;
    logic [7:0] staging;
    logic       rd_rise, wr_rise, wr_commit;

    assign rd_rise = ~rdn_d & uart_rdn;
    assign wr_rise = ~wrn_d & uart_wrn;
    // A write is only committed if it was never overlapped by a read strobe.
    assign wr_commit = wr_rise & uart_tbre & ~wr_bad;

    logic [7:0] rbr;
    assign uart_data = (~uart_rdn & uart_wrn) ? rbr : 'z;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdn_d   <= 1'b1;
            wrn_d   <= 1'b1;
            wr_bad  <= 1'b0;
            staging <= '0;
        end else begin
            rdn_d <= uart_rdn;
            wrn_d <= uart_wrn;
            if (!uart_wrn && uart_rdn)
                staging <= uart_data;
            if (wr_rise)
                wr_bad <= 1'b0;
            else if (!uart_wrn && !uart_rdn)
                wr_bad <= 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    thr, tsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            thr       <= '0;
            tsr       <= '0;
            txd       <= 1'b1;
            uart_tbre <= 1'b1;
            uart_tsre <= 1'b1;
        end else begin
            // Commit needs tbre=1 while every THR load below needs tbre=0,
            // so a write landing on a load cycle is dropped naturally.
            if (wr_commit) begin
                thr       <= staging;
                uart_tbre <= 1'b0;
            end
            case (tx_state)
                S_IDLE: begin
                    if (!uart_tbre) begin
                        tsr       <= thr;
                        uart_tbre <= 1'b1;
                        uart_tsre <= 1'b0;
                        txd       <= 1'b0;
                        tx_cnt    <= '0;
                        tx_state  <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        txd      <= tsr[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            txd      <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            txd    <= tsr[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin // S_STOP
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (!uart_tbre) begin
                            // back-to-back reload, no idle bit between frames
                            tsr       <= thr;
                            uart_tbre <= 1'b1;
                            txd       <= 1'b0;
                            tx_state  <= S_START;
                        end else begin
                            uart_tsre <= 1'b1;
                            tx_state  <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_fall;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;

    assign rx_fall = rx_s3 & ~rx_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_s3          <= 1'b1;
            rx_state       <= S_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_sh          <= '0;
            rbr            <= '0;
            uart_dataready <= 1'b0;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
            // Placed first so a frame completing on the same cycle wins.
            if (rd_rise)
                uart_dataready <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin // S_STOP
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rbr            <= rx_sh;
                            uart_dataready <= 1'b1;
                        end
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
